// File: rtl/line_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : quadrant_finder / line_step_sequencer
// Description : Turns one signed relative move into paced X/Y step pulses,
//               using a Bresenham walk so both axes finish on the same tick.
// Revision    : 1.0 - initial release
// ============================================================================

// Quadrant encoding: 0 = (+x,+y), 1 = (-x,+y), 2 = (-x,-y), 3 = (+x,-y).
// A zero component counts as non-negative.
module quadrant_finder #(
    parameter int NUM_BITS = 8
) (
    input  logic [NUM_BITS-1:0] rel_x,
    input  logic [NUM_BITS-1:0] rel_y,
    output logic [1:0]          quadrant
);
    logic w_neg_x;
    logic w_neg_y;

    assign w_neg_x  = rel_x[NUM_BITS-1];
    assign w_neg_y  = rel_y[NUM_BITS-1];
    assign quadrant = {w_neg_y, w_neg_x ^ w_neg_y};
endmodule

module line_step_sequencer #(
    parameter int NUM_BITS = 8,
    parameter int STEP_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] rel_x,
    input  logic [NUM_BITS-1:0] rel_y,
    output logic [1:0]          quadrant,
    output logic                dir_x,
    output logic                dir_y,
    output logic                step_x,
    output logic                step_y,
    output logic                busy,
    output logic                done
);
    localparam int c_EW = NUM_BITS + 2;
    localparam int c_PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_PW-1:0]     c_LAST  = c_PW'(STEP_DIV - 1);
    localparam logic [c_PW-1:0]     c_PONE  = {{(c_PW-1){1'b0}}, 1'b1};
    localparam logic [NUM_BITS-1:0] c_ONE   = {{(NUM_BITS-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [NUM_BITS-1:0]    r_rel_x;
    logic [NUM_BITS-1:0]    r_rel_y;
    logic [NUM_BITS-1:0]    r_abs_x;
    logic [NUM_BITS-1:0]    r_abs_y;
    logic [NUM_BITS-1:0]    r_rem_x;
    logic [NUM_BITS-1:0]    r_rem_y;
    logic signed [c_EW-1:0] r_err;
    logic [c_PW-1:0]        r_presc;
    logic [1:0]             r_quadrant;
    logic                   r_dir_x;
    logic                   r_dir_y;
    logic                   r_step_x;
    logic                   r_step_y;

    logic [1:0]             w_quadrant;
    logic [NUM_BITS-1:0]    w_abs_x;
    logic [NUM_BITS-1:0]    w_abs_y;
    logic                   w_tick;
    logic signed [c_EW:0]   w_e2;
    logic signed [c_EW:0]   w_ax_e;
    logic signed [c_EW:0]   w_ay_e;
    logic                   w_go_x;
    logic                   w_go_y;
    logic [NUM_BITS-1:0]    w_rem_x_next;
    logic [NUM_BITS-1:0]    w_rem_y_next;
    logic [c_EW-1:0]        w_err_sub;
    logic [c_EW-1:0]        w_err_add;
    logic                   w_finish;

    quadrant_finder #(.NUM_BITS(NUM_BITS)) u_quadrant_finder (
        .rel_x    (r_rel_x),
        .rel_y    (r_rel_y),
        .quadrant (w_quadrant)
    );

    // Negating the most negative value wraps to 2^(NUM_BITS-1), which is exact unsigned.
    assign w_abs_x = r_rel_x[NUM_BITS-1] ? (~r_rel_x + c_ONE) : r_rel_x;
    assign w_abs_y = r_rel_y[NUM_BITS-1] ? (~r_rel_y + c_ONE) : r_rel_y;

    assign w_tick = (r_state == S_RUN) && (r_presc == c_LAST);
    assign w_e2   = {r_err, 1'b0};
    assign w_ax_e = {3'b000, r_abs_x};
    assign w_ay_e = {3'b000, r_abs_y};

    // An exhausted axis forces the other to step, so the walk never stalls.
    assign w_go_x = ((w_e2 > -w_ay_e) && (r_rem_x != '0)) || (r_rem_y == '0);
    assign w_go_y = ((w_e2 <  w_ax_e) && (r_rem_y != '0)) || (r_rem_x == '0);

    assign w_rem_x_next = r_rem_x - (w_go_x ? c_ONE : '0);
    assign w_rem_y_next = r_rem_y - (w_go_y ? c_ONE : '0);
    assign w_err_sub    = w_go_x ? {2'b00, r_abs_y} : '0;
    assign w_err_add    = w_go_y ? {2'b00, r_abs_x} : '0;
    assign w_finish     = (w_rem_x_next == '0) && (w_rem_y_next == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next_state = S_SETUP;
            S_SETUP: w_next_state = ((w_abs_x == '0) && (w_abs_y == '0)) ? S_DONE : S_RUN;
            S_RUN:   if (w_tick && w_finish) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rel_x    <= '0;
            r_rel_y    <= '0;
            r_abs_x    <= '0;
            r_abs_y    <= '0;
            r_rem_x    <= '0;
            r_rem_y    <= '0;
            r_err      <= '0;
            r_presc    <= '0;
            r_quadrant <= '0;
            r_dir_x    <= 1'b0;
            r_dir_y    <= 1'b0;
            r_step_x   <= 1'b0;
            r_step_y   <= 1'b0;
        end else begin
            r_step_x <= w_tick && w_go_x;
            r_step_y <= w_tick && w_go_y;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_rel_x <= rel_x;
                        r_rel_y <= rel_y;
                    end
                end
                S_SETUP: begin
                    r_quadrant <= w_quadrant;
                    r_dir_x    <= r_rel_x[NUM_BITS-1];
                    r_dir_y    <= r_rel_y[NUM_BITS-1];
                    r_abs_x    <= w_abs_x;
                    r_abs_y    <= w_abs_y;
                    r_rem_x    <= w_abs_x;
                    r_rem_y    <= w_abs_y;
                    r_err      <= $signed({2'b00, w_abs_x}) - $signed({2'b00, w_abs_y});
                    r_presc    <= '0;
                end
                S_RUN: begin
                    r_presc <= (r_presc == c_LAST) ? '0 : r_presc + c_PONE;
                    if (w_tick) begin
                        r_rem_x <= w_rem_x_next;
                        r_rem_y <= w_rem_y_next;
                        r_err   <= r_err - $signed(w_err_sub) + $signed(w_err_add);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready = (r_state == S_IDLE) && !reset;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign quadrant = r_quadrant;
    assign dir_x    = r_dir_x;
    assign dir_y    = r_dir_y;
    assign step_x   = r_step_x;
    assign step_y   = r_step_y;
endmodule
`default_nettype wire

// File: tb/tb_line_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_step_sequencer
// Description : Table, directed and random moves on STEP_DIV=4 and STEP_DIV=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_step_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       reset_v;
    logic [1:0]       in_valid_v;
    logic [1:0]       in_ready_v;
    logic [1:0][7:0]  rel_x_v;
    logic [1:0][7:0]  rel_y_v;
    logic [1:0][1:0]  quad_v;
    logic [1:0]       dir_x_v;
    logic [1:0]       dir_y_v;
    logic [1:0]       step_x_v;
    logic [1:0]       step_y_v;
    logic [1:0]       busy_v;
    logic [1:0]       done_v;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            line_step_sequencer #(.NUM_BITS(8), .STEP_DIV((g == 0) ? 4 : 1)) u_dut (
                .clk      (clk),
                .reset    (reset_v[g]),
                .in_valid (in_valid_v[g]),
                .in_ready (in_ready_v[g]),
                .rel_x    (rel_x_v[g]),
                .rel_y    (rel_y_v[g]),
                .quadrant (quad_v[g]),
                .dir_x    (dir_x_v[g]),
                .dir_y    (dir_y_v[g]),
                .step_x   (step_x_v[g]),
                .step_y   (step_y_v[g]),
                .busy     (busy_v[g]),
                .done     (done_v[g])
            );
        end
    endgenerate

    typedef struct {
        int d; int rx; int ry; int ex; int ey; int lat; int dx; int dy; int q;
    } vec_t;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int quad_of(input int rx, input int ry);
        if (ry < 0) return (rx < 0) ? 2 : 3;
        return (rx < 0) ? 1 : 0;
    endfunction

    function automatic int all_outs(input int d);
        return int'({quad_v[d], dir_x_v[d], dir_y_v[d], step_x_v[d], step_y_v[d],
                     busy_v[d], done_v[d]});
    endfunction

    // Accept cycle is k=0; k counts clocks after it. in_valid stays high with junk
    // data while busy, so the DUT must ignore it.
    task automatic run_move(input vec_t v, input string tag);
        int sd;
        int k;
        int cx;
        int cy;
        int dk;
        int bad;
        sd = (v.d == 0) ? 4 : 1;
        k  = 0;
        @(negedge clk);
        while (!in_ready_v[v.d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " in_ready"}, int'(in_ready_v[v.d]), 1);
        in_valid_v[v.d] = 1'b1;
        rel_x_v[v.d]    = v.rx[7:0];
        rel_y_v[v.d]    = v.ry[7:0];
        @(posedge clk);
        #1;
        rel_x_v[v.d] = 8'($urandom);
        rel_y_v[v.d] = 8'($urandom);
        k = 1; cx = 0; cy = 0; dk = 0; bad = 0;
        while (dk == 0 && k < 600) begin
            if (step_x_v[v.d]) begin
                cx++;
                if (k < 2 + sd || (k - 2) % sd != 0) bad++;
            end
            if (step_y_v[v.d]) begin
                cy++;
                if (k < 2 + sd || (k - 2) % sd != 0) bad++;
            end
            if (!busy_v[v.d]) bad++;
            if (done_v[v.d]) dk = k;
            else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        in_valid_v[v.d] = 1'b0;
        chk({tag, " step_x count"}, cx, v.ex);
        chk({tag, " step_y count"}, cy, v.ey);
        chk({tag, " done latency"}, dk, v.lat);
        chk({tag, " dir_x"}, int'(dir_x_v[v.d]), v.dx);
        chk({tag, " dir_y"}, int'(dir_y_v[v.d]), v.dy);
        chk({tag, " quadrant"}, int'(quad_v[v.d]), v.q);
        chk({tag, " pulse timing/busy errors"}, bad, 0);
        @(posedge clk);
        #1;
        chk({tag, " quiet after done"},
            int'({step_x_v[v.d], step_y_v[v.d], busy_v[v.d], done_v[v.d]}), 0);
        chk({tag, " in_ready after done"}, int'(in_ready_v[v.d]), 1);
    endtask

    function automatic vec_t model(input int d, input int rx, input int ry);
        vec_t v;
        int   m;
        m     = (iabs(rx) > iabs(ry)) ? iabs(rx) : iabs(ry);
        v.d   = d;
        v.rx  = rx;
        v.ry  = ry;
        v.ex  = iabs(rx);
        v.ey  = iabs(ry);
        v.lat = (m == 0) ? 2 : 2 + ((d == 0) ? 4 : 1) * m;
        v.dx  = (rx < 0) ? 1 : 0;
        v.dy  = (ry < 0) ? 1 : 0;
        v.q   = quad_of(rx, ry);
        return v;
    endfunction

    vec_t tbl[10];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   k;
        tbl[0] = '{0,    0,    0,   0,   0,   2, 0, 0, 0};
        tbl[1] = '{0,    1,    2,   1,   2,  10, 0, 0, 0};
        tbl[2] = '{0,   -4,    2,   4,   2,  18, 1, 0, 1};
        tbl[3] = '{0,   -5,   -4,   5,   4,  22, 1, 1, 2};
        tbl[4] = '{1, -128,  127, 128, 127, 130, 1, 0, 1};
        tbl[5] = '{1,  127, -128, 127, 128, 130, 0, 1, 3};
        tbl[6] = '{0,    0,   -3,   0,   3,  14, 0, 1, 3};
        tbl[7] = '{0,    6,    0,   6,   0,  26, 0, 0, 0};
        tbl[8] = '{1, -128, -128, 128, 128, 130, 1, 1, 2};
        tbl[9] = '{1,    0,    0,   0,   0,   2, 0, 0, 0};

        reset_v    = 2'b11;
        in_valid_v = 2'b00;
        rel_x_v    = '0;
        rel_y_v    = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset in_ready dut%0d", d), int'(in_ready_v[d]), 0);
            chk($sformatf("reset outputs dut%0d", d), all_outs(d), 0);
        end
        @(negedge clk);
        reset_v = 2'b00;
        #1;
        chk("in_ready after reset release", int'(in_ready_v[0]), 1);

        for (int i = 0; i < 10; i++) run_move(tbl[i], $sformatf("vec%0d", i));

        // Reset during a move: next clock all quiet, then a fresh move works.
        @(negedge clk);
        in_valid_v[0] = 1'b1;
        rel_x_v[0]    = 8'd2;
        rel_y_v[0]    = 8'hFE;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        k = 1;
        while (!(step_x_v[0] || step_y_v[0]) && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("midreset first pulse cycle", k, 6);
        @(negedge clk);
        reset_v[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset outputs", all_outs(0), 0);
        chk("midreset in_ready", int'(in_ready_v[0]), 0);
        @(negedge clk);
        reset_v[0] = 1'b0;
        run_move(model(0, 1, 0), "after midreset");

        for (int i = 0; i < 24; i++) begin
            int rx;
            int ry;
            rx = int'($urandom_range(0, 255)) - 128;
            ry = int'($urandom_range(0, 255)) - 128;
            if (i % 2 == 0) begin
                rx = rx / 8;
                ry = ry / 8;
            end
            v = model(i % 2, rx, ry);
            run_move(v, $sformatf("rand%0d (%0d,%0d)", i, rx, ry));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
